mem_lsu_stage: RTL

Parametrised memory stage for the five-stage pipeline, between EX and WB. It registers the EX result, waits on a variable-latency data SRAM read response, and sign/zero-extends and aligns load data. It requests a pipeline stall while a load response is outstanding and drives the WB and ID-forwarding buses. It also discards the in-flight response of a flushed load.

---
 rtl/mem_lsu_stage_pkg.sv | 48 ++++
 rtl/mem_lsu_stage_load_align_ext.sv | 29 ++
 rtl/mem_lsu_stage.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_lsu_stage_pkg.sv
// Shared types for the MEM stage: load-type codes, FSM encoding, stall bus and bus widths.
// The misalignment helper is only called when MEM_MISALIGN_CHECK_EN is defined.
package mem_lsu_stage_pkg;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LD  = 3'b011,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101,
    LD_LWU = 3'b110,
    LD_RSV = 3'b111
  } ld_type_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } mem_state_e;

  typedef logic [5:0] StallBus;
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;
  localparam int STALL_EX_MEM = 3;
  localparam int STALL_MEM_WB = 4;

  function automatic int MEM_TO_WB_WD(input int pc_w, input int data_w);
    return pc_w + 6 + data_w;
  endfunction

  function automatic int MEM_TO_ID_WD(input int data_w);
    return 7 + data_w;
  endfunction

  // Reserved code, LWU and (at 32 bits) LD are all checked as words.
  function automatic logic is_misaligned(input logic [2:0] ld_type, input logic [2:0] addr_lo,
                                         input int data_w);
    case (ld_type)
      LD_LB, LD_LBU: is_misaligned = 1'b0;
      LD_LH, LD_LHU: is_misaligned = addr_lo[0];
      LD_LD:         is_misaligned = (data_w == 64) ? |addr_lo : |addr_lo[1:0];
      default:       is_misaligned = |addr_lo[1:0];
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_stage_load_align_ext.sv
// Combinational load aligner: picks the addressed lane (little-endian) and sign/zero-extends.
module load_align_ext
  import mem_lsu_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [OFF_W-1:0]  offset_i,
  input  logic [2:0]        ld_type_i,
  output logic [DATA_W-1:0] ext_o
);

  logic [DATA_W-1:0] sh;

  always_comb begin
    sh = rdata_i >> {offset_i, 3'b000};
    case (ld_type_i)
      LD_LB:   ext_o = DATA_W'($signed(sh[7:0]));
      LD_LBU:  ext_o = DATA_W'(sh[7:0]);
      LD_LH:   ext_o = DATA_W'($signed(sh[15:0]));
      LD_LHU:  ext_o = DATA_W'(sh[15:0]);
      LD_LD:   ext_o = (DATA_W == 64) ? sh : DATA_W'($signed(sh[31:0]));
      LD_LWU:  ext_o = (DATA_W == 64) ? DATA_W'(sh[31:0]) : DATA_W'($signed(sh[31:0]));
      default: ext_o = DATA_W'($signed(sh[31:0]));
    endcase
  end

endmodule

// File: rtl/mem_lsu_stage.sv
// MEM pipeline stage: registers EX results, waits on SRAM load responses, drives WB/ID buses.
// Optional misaligned-load detection and mem_excp output under MEM_MISALIGN_CHECK_EN.
module mem_lsu_stage
  import mem_lsu_stage_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  StallBus                               stall,
  input  logic                                  flush,
  input  logic                                  ex_valid,
  input  logic [PC_W-1:0]                       ex_pc,
  input  logic                                  ex_load,
  input  logic [2:0]                            ex_ld_type,
  input  logic                                  ex_rf_we,
  input  logic [4:0]                            ex_rf_waddr,
  input  logic [DATA_W-1:0]                     ex_result,
  input  logic                                  data_sram_rvalid,
  input  logic [DATA_W-1:0]                     data_sram_rdata,
  output logic                                  stallreq_mem,
  output logic [MEM_TO_WB_WD(PC_W, DATA_W)-1:0] mem_to_wb_bus,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic                                  mem_excp,
`endif
  output logic [MEM_TO_ID_WD(DATA_W)-1:0]       mem_to_id_bus
);

  localparam int OFF_W = $clog2(DATA_W / 8);

  mem_state_e        state_q, state_d, entry_state;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              load_q, load_d, rf_we_q, rf_we_d, misalign_q, misalign_d;
  logic [2:0]        ld_type_q, ld_type_d;
  logic [4:0]        waddr_q, waddr_d;
  logic [DATA_W-1:0] result_q, result_d, ldbuf_q, ldbuf_d, ext_data;
  logic              take_ex, advance, resp, entry_misalign;
  logic              fwd_pending, rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic              unused_stall;

  assign unused_stall = ^{stall[5], stall[2:0]};

  load_align_ext #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_align (
    .rdata_i   (data_sram_rdata),
    .offset_i  (result_q[OFF_W-1:0]),
    .ld_type_i (ld_type_q),
    .ext_o     (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      pc_q       <= '0;
      load_q     <= 1'b0;
      ld_type_q  <= '0;
      rf_we_q    <= 1'b0;
      waddr_q    <= '0;
      result_q   <= '0;
      ldbuf_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      load_q     <= load_d;
      ld_type_q  <= ld_type_d;
      rf_we_q    <= rf_we_d;
      waddr_q    <= waddr_d;
      result_q   <= result_d;
      ldbuf_q    <= ldbuf_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    advance = (stall[STALL_EX_MEM] == NoStop) || (stall[STALL_MEM_WB] == NoStop);
    take_ex = ex_valid && (stall[STALL_EX_MEM] == NoStop) && !flush;
    resp    = (state_q == ST_WAIT) && data_sram_rvalid;
    entry_misalign = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    entry_misalign = ex_load && is_misaligned(ex_ld_type, ex_result[2:0], DATA_W);
`endif
    // A misaligned load never had its SRAM request issued, so it must not wait.
    if (!take_ex)                           entry_state = ST_EMPTY;
    else if (ex_load && !entry_misalign)    entry_state = ST_WAIT;
    else                                    entry_state = ST_HOLD;

    pc_d       = pc_q;
    load_d     = load_q;
    ld_type_d  = ld_type_q;
    rf_we_d    = rf_we_q;
    waddr_d    = waddr_q;
    result_d   = result_q;
    misalign_d = misalign_q;
    ldbuf_d    = (resp && !flush) ? ext_data : ldbuf_q;
    if (flush || advance) begin
      pc_d       = take_ex ? ex_pc : '0;
      load_d     = take_ex && ex_load;
      ld_type_d  = take_ex ? ex_ld_type : '0;
      rf_we_d    = take_ex && ex_rf_we;
      waddr_d    = take_ex ? ex_rf_waddr : '0;
      result_d   = take_ex ? ex_result : '0;
      misalign_d = take_ex && entry_misalign;
    end

    state_d = state_q;
    case (state_q)
      ST_DRAIN: state_d = data_sram_rvalid ? ST_EMPTY : ST_DRAIN;
      ST_WAIT: begin
        if (flush)        state_d = data_sram_rvalid ? ST_EMPTY : ST_DRAIN;
        else if (advance) state_d = entry_state;
        else if (resp)    state_d = ST_HOLD;
      end
      default: begin
        if (flush)        state_d = ST_EMPTY;
        else if (advance) state_d = entry_state;
      end
    endcase
  end

  always_comb begin
    fwd_pending  = (state_q == ST_WAIT) && !data_sram_rvalid;
    stallreq_mem = fwd_pending || (state_q == ST_DRAIN);
    rf_we        = 1'b0;
    rf_wdata     = '0;
    case (state_q)
      ST_HOLD: begin
        rf_we    = rf_we_q && !misalign_q;
        rf_wdata = load_q ? ldbuf_q : result_q;
      end
      ST_WAIT: begin
        rf_we    = rf_we_q && data_sram_rvalid;
        rf_wdata = data_sram_rvalid ? ext_data : '0;
      end
      default: ;
    endcase
  end

  assign mem_to_wb_bus = {pc_q, rf_we, waddr_q, rf_wdata};
  assign mem_to_id_bus = {fwd_pending, rf_we, waddr_q, rf_wdata};
`ifdef MEM_MISALIGN_CHECK_EN
  assign mem_excp = (state_q == ST_HOLD) && misalign_q;
`endif

endmodule
